// File: rtl/uart_rx_fifo_if.sv
// Receive-side bus of uart_rx_fifo: FWFT data handshake, per-frame status
// pulses and FIFO occupancy.
interface uart_rx_fifo_if #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 8
);
   logic [DATA_WIDTH-1:0]         o_data;
   logic                          o_valid;
   logic                          i_ready;
   logic                          o_parity_err;
   logic                          o_frame_err;
   logic                          o_break;
   logic                          o_overflow;
   logic [$clog2(FIFO_DEPTH):0]   o_fifo_level;

   modport master (
      output o_data, o_valid, o_parity_err, o_frame_err, o_break, o_overflow, o_fifo_level,
      input  i_ready
   );

   modport slave (
      input  o_data, o_valid, o_parity_err, o_frame_err, o_break, o_overflow, o_fifo_level,
      output i_ready
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with majority-vote sampling, configurable frame
// format, per-frame error/break qualification and a FWFT receive FIFO.
module uart_rx_fifo #(
   parameter int CLK_FRE     = 50,
   parameter int BAUD_RATE   = 9600,
   parameter int DATA_WIDTH  = 8,
   parameter int PARITY_ON   = 0,
   parameter int PARITY_TYPE = 0,
   parameter int STOP_BITS   = 1,
   parameter int OVS         = 16,
   parameter int FIFO_DEPTH  = 8
) (
   input  logic           i_clk_sys,
   input  logic           i_rst_n,
   input  logic           i_uart_rx,
   uart_rx_fifo_if.master bus
);
   localparam int DIV   = (CLK_FRE * 1000000) / (BAUD_RATE * OVS);
   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int OVS_W = $clog2(OVS);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_PARITY    = 3'd3,
      ST_STOP      = 3'd4,
      ST_WAIT_HIGH = 3'd5
   } state_t;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   function automatic logic parity_of(input logic [DATA_WIDTH-1:0] d, input logic odd);
      return (^d) ^ odd;
   endfunction

   logic                  rx_meta_r, rx_sync_r, rx_prev_r;
   logic [1:0]            prime_r;
   logic                  arm_r;
   logic [DIV_W-1:0]      div_cnt_r;
   logic [OVS_W-1:0]      ovs_cnt_r;
   logic                  samp0_r, samp1_r;
   state_t                state_r, state_nx_s;
   logic [3:0]            bit_cnt_r;
   logic [DATA_WIDTH-1:0] shift_r;
   logic                  par_bit_r, perr_r, ferr_r;
   logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_r, rd_ptr_r;
   logic [LVL_W-1:0]      level_r;
   logic                  perr_pulse_r, ferr_pulse_r, brk_pulse_r, ovf_pulse_r;

   logic fall_s, start_s, tick_s, dec_s, bit_s, done_s;
   logic ferr_fin_s, brk_s, push_req_s, full_s, push_s, pop_s;

   assign fall_s     = arm_r & rx_prev_r & ~rx_sync_r;
   assign start_s    = (state_r == ST_IDLE) & fall_s;
   assign tick_s     = (div_cnt_r == DIV_W'(DIV - 1));
   assign dec_s      = tick_s & (ovs_cnt_r == OVS_W'(OVS / 2 + 1));
   assign bit_s      = maj3(samp0_r, samp1_r, rx_sync_r);
   assign ferr_fin_s = ferr_r | ~bit_s;
   assign brk_s      = (shift_r == {DATA_WIDTH{1'b0}}) & ((PARITY_ON == 0) | ~par_bit_r) & ferr_fin_s;
   assign push_req_s = done_s & ~ferr_fin_s & ~perr_r;
   assign full_s     = (level_r == LVL_W'(FIFO_DEPTH));
   assign push_s     = push_req_s & ~full_s;
   assign pop_s      = (level_r != {LVL_W{1'b0}}) & bus.i_ready;

   // Line synchroniser; arming waits until real line samples replace the reset value.
   always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rx_meta_r <= 1'b1;
         rx_sync_r <= 1'b1;
         rx_prev_r <= 1'b1;
         prime_r   <= 2'b00;
         arm_r     <= 1'b0;
      end else begin
         rx_meta_r <= i_uart_rx;
         rx_sync_r <= rx_meta_r;
         rx_prev_r <= rx_sync_r;
         prime_r   <= {prime_r[0], 1'b1};
         arm_r     <= arm_r | (prime_r[1] & rx_sync_r);
      end
   end

   // Oversampling tick and per-bit tick counter, realigned on each start edge.
   always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
      if (!i_rst_n) begin
         div_cnt_r <= {DIV_W{1'b0}};
         ovs_cnt_r <= {OVS_W{1'b0}};
         samp0_r   <= 1'b1;
         samp1_r   <= 1'b1;
      end else if (start_s) begin
         div_cnt_r <= {DIV_W{1'b0}};
         ovs_cnt_r <= {OVS_W{1'b0}};
      end else if (tick_s) begin
         div_cnt_r <= {DIV_W{1'b0}};
         ovs_cnt_r <= (ovs_cnt_r == OVS_W'(OVS - 1)) ? {OVS_W{1'b0}} : ovs_cnt_r + OVS_W'(1);
         if (ovs_cnt_r == OVS_W'(OVS / 2 - 1)) samp0_r <= rx_sync_r;
         if (ovs_cnt_r == OVS_W'(OVS / 2))     samp1_r <= rx_sync_r;
      end else begin
         div_cnt_r <= div_cnt_r + DIV_W'(1);
      end
   end

   // FSM state register.
   always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
      if (!i_rst_n) state_r <= ST_IDLE;
      else          state_r <= state_nx_s;
   end

   // Next-state decode; done_s marks the final stop-bit decision tick.
   always_comb begin
      state_nx_s = state_r;
      done_s     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (fall_s) state_nx_s = ST_START;
            else        state_nx_s = ST_IDLE;
         end
         ST_START: begin
            if (dec_s) state_nx_s = bit_s ? ST_IDLE : ST_DATA;
            else       state_nx_s = ST_START;
         end
         ST_DATA: begin
            if (dec_s && bit_cnt_r == 4'(DATA_WIDTH - 1))
               state_nx_s = (PARITY_ON != 0) ? ST_PARITY : ST_STOP;
            else
               state_nx_s = ST_DATA;
         end
         ST_PARITY: begin
            if (dec_s) state_nx_s = ST_STOP;
            else       state_nx_s = ST_PARITY;
         end
         ST_STOP: begin
            if (dec_s && bit_cnt_r == 4'(STOP_BITS - 1)) begin
               done_s     = 1'b1;
               state_nx_s = bit_s ? ST_IDLE : ST_WAIT_HIGH;
            end else begin
               state_nx_s = ST_STOP;
            end
         end
         ST_WAIT_HIGH: begin
            if (rx_sync_r) state_nx_s = ST_IDLE;
            else           state_nx_s = ST_WAIT_HIGH;
         end
         default: state_nx_s = ST_IDLE;
      endcase
   end

   // Frame datapath: shift register, parity/stop error latches, bit counter.
   always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
      if (!i_rst_n) begin
         bit_cnt_r <= 4'd0;
         shift_r   <= {DATA_WIDTH{1'b0}};
         par_bit_r <= 1'b0;
         perr_r    <= 1'b0;
         ferr_r    <= 1'b0;
      end else begin
         if (state_nx_s != state_r)
            bit_cnt_r <= 4'd0;
         else if (dec_s && (state_r == ST_DATA || state_r == ST_STOP))
            bit_cnt_r <= bit_cnt_r + 4'd1;
         if (start_s) begin
            perr_r <= 1'b0;
            ferr_r <= 1'b0;
         end else if (dec_s) begin
            case (state_r)
               ST_DATA:   shift_r <= {bit_s, shift_r[DATA_WIDTH-1:1]};
               ST_PARITY: begin
                  par_bit_r <= bit_s;
                  perr_r    <= bit_s != parity_of(shift_r, PARITY_TYPE != 0);
               end
               ST_STOP:   if (!bit_s) ferr_r <= 1'b1;
               default:   ;
            endcase
         end
      end
   end

   // Completion pulses (mutually exclusive, break first) and FWFT FIFO storage.
   always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
      if (!i_rst_n) begin
         perr_pulse_r <= 1'b0;
         ferr_pulse_r <= 1'b0;
         brk_pulse_r  <= 1'b0;
         ovf_pulse_r  <= 1'b0;
         wr_ptr_r     <= {PTR_W{1'b0}};
         rd_ptr_r     <= {PTR_W{1'b0}};
         level_r      <= {LVL_W{1'b0}};
         for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= {DATA_WIDTH{1'b0}};
      end else begin
         brk_pulse_r  <= done_s & brk_s;
         ferr_pulse_r <= done_s & ferr_fin_s & ~brk_s;
         perr_pulse_r <= done_s & ~ferr_fin_s & perr_r;
         ovf_pulse_r  <= push_req_s & full_s;
         if (push_s) begin
            mem_r[wr_ptr_r] <= shift_r;
            wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         case ({push_s, pop_s})
            2'b10:   level_r <= level_r + LVL_W'(1);
            2'b01:   level_r <= level_r - LVL_W'(1);
            default: level_r <= level_r;
         endcase
      end
   end

   assign bus.o_data       = mem_r[rd_ptr_r];
   assign bus.o_valid      = (level_r != {LVL_W{1'b0}});
   assign bus.o_fifo_level = level_r;
   assign bus.o_parity_err = perr_pulse_r;
   assign bus.o_frame_err  = ferr_pulse_r;
   assign bus.o_break      = brk_pulse_r;
   assign bus.o_overflow   = ovf_pulse_r;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench: dut_a is 8N1 with an 8-deep FIFO, dut_b is 8E1 with a
// 4-deep FIFO; monitors pop expected words and status pulses as they appear.
module tb_uart_rx_fifo;
   localparam int BIT = 432;
   localparam logic [3:0] P_BRK = 4'b1000, P_FERR = 4'b0100, P_PERR = 4'b0010, P_OVF = 4'b0001;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rx_a = 1'b1;
   logic rx_b = 1'b1;
   int   pass_cnt = 0;
   int   total_cnt = 0;

   logic [7:0] qd_a[$], qd_b[$];
   logic [3:0] qp_a[$], qp_b[$];
   logic [3:0] pv_a, pv_b;

   uart_rx_fifo_if #(.DATA_WIDTH(8), .FIFO_DEPTH(8)) bus_a ();
   uart_rx_fifo_if #(.DATA_WIDTH(8), .FIFO_DEPTH(4)) bus_b ();

   uart_rx_fifo #(.CLK_FRE(50), .BAUD_RATE(115200), .DATA_WIDTH(8), .PARITY_ON(0),
                  .PARITY_TYPE(0), .STOP_BITS(1), .OVS(16), .FIFO_DEPTH(8))
   dut_a (.i_clk_sys(clk), .i_rst_n(rst_n), .i_uart_rx(rx_a), .bus(bus_a.master));

   uart_rx_fifo #(.CLK_FRE(50), .BAUD_RATE(115200), .DATA_WIDTH(8), .PARITY_ON(1),
                  .PARITY_TYPE(0), .STOP_BITS(1), .OVS(16), .FIFO_DEPTH(4))
   dut_b (.i_clk_sys(clk), .i_rst_n(rst_n), .i_uart_rx(rx_b), .bus(bus_b.master));

   always #10 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic unexpected(input string name, input int act);
      total_cnt++;
      $display("FAIL %s: got 0x%0h, expected nothing", name, act);
   endtask

   // Monitors: compare each accepted head word and each status pulse in order.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus_a.o_valid && bus_a.i_ready) begin
            if (qd_a.size() == 0) unexpected("a_data", bus_a.o_data);
            else check("a_data", bus_a.o_data, qd_a.pop_front());
         end
         pv_a = {bus_a.o_break, bus_a.o_frame_err, bus_a.o_parity_err, bus_a.o_overflow};
         if (pv_a != 4'b0000) begin
            if (qp_a.size() == 0) unexpected("a_pulse", pv_a);
            else check("a_pulse", pv_a, qp_a.pop_front());
         end
         if (bus_b.o_valid && bus_b.i_ready) begin
            if (qd_b.size() == 0) unexpected("b_data", bus_b.o_data);
            else check("b_data", bus_b.o_data, qd_b.pop_front());
         end
         pv_b = {bus_b.o_break, bus_b.o_frame_err, bus_b.o_parity_err, bus_b.o_overflow};
         if (pv_b != 4'b0000) begin
            if (qp_b.size() == 0) unexpected("b_pulse", pv_b);
            else check("b_pulse", pv_b, qp_b.pop_front());
         end
      end
   end

   task automatic set_rx(input int which, input logic v);
      if (which == 0) rx_a = v;
      else rx_b = v;
   endtask

   task automatic hold(input int which, input logic v, input int clks);
      for (int c = 0; c < clks; c++) begin
         @(posedge clk); #1;
         set_rx(which, v);
      end
   endtask

   // Sends one frame; glitch_bit inverts ~20 clocks around the middle sample of that frame bit.
   task automatic send(input int which, input logic [7:0] d, input logic par_on,
                       input logic par_v, input logic stop_v, input int glitch_bit);
      logic [11:0] bits;
      logic        v;
      int          n;
      bits = 12'h000;
      for (int i = 0; i < 8; i++) bits[i+1] = d[i];
      n = 9;
      if (par_on) begin
         bits[9] = par_v;
         n = 10;
      end
      bits[n] = stop_v;
      n++;
      for (int i = 0; i < n; i++) begin
         for (int c = 0; c < BIT; c++) begin
            @(posedge clk); #1;
            v = bits[i];
            if (i == glitch_bit && c >= 235 && c < 255) v = ~v;
            set_rx(which, v);
         end
      end
      hold(which, 1'b1, 2 * BIT);
   endtask

   task automatic drain();
      for (int c = 0; c < 2000; c++) begin
         if (qd_a.size() == 0 && qd_b.size() == 0 && qp_a.size() == 0 && qp_b.size() == 0) break;
         @(posedge clk);
      end
   endtask

   initial begin
      bus_a.i_ready = 1'b1;
      bus_b.i_ready = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("rst_a_valid", bus_a.o_valid, 0);
      check("rst_a_level", bus_a.o_fifo_level, 0);
      check("rst_a_data", bus_a.o_data, 0);
      check("rst_a_pulses", {bus_a.o_break, bus_a.o_frame_err, bus_a.o_parity_err, bus_a.o_overflow}, 0);
      check("rst_b_valid", bus_b.o_valid, 0);
      check("rst_b_level", bus_b.o_fifo_level, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      hold(0, 1'b1, 2 * BIT);

      // dut_a: basic 8N1, majority vote, idle glitch, framing error, break.
      qd_a.push_back(8'hA5);
      send(0, 8'hA5, 1'b0, 1'b0, 1'b1, -1);
      qd_a.push_back(8'h3A);
      send(0, 8'h3A, 1'b0, 1'b0, 1'b1, 4);
      qd_a.push_back(8'h81);
      send(0, 8'h81, 1'b0, 1'b0, 1'b1, 1);
      hold(0, 1'b0, 2);
      hold(0, 1'b1, 2 * BIT);
      @(negedge clk);
      check("a_glitch_level", bus_a.o_fifo_level, 0);
      qp_a.push_back(P_FERR);
      send(0, 8'h55, 1'b0, 1'b0, 1'b0, -1);
      qd_a.push_back(8'hC3);
      send(0, 8'hC3, 1'b0, 1'b0, 1'b1, -1);
      qp_a.push_back(P_BRK);
      hold(0, 1'b0, 20 * BIT);
      hold(0, 1'b1, 2 * BIT);
      @(negedge clk);
      check("a_break_level", bus_a.o_fifo_level, 0);

      // dut_b: even parity good and bad.
      qd_b.push_back(8'h03);
      send(1, 8'h03, 1'b1, 1'b0, 1'b1, -1);
      qp_b.push_back(P_PERR);
      send(1, 8'h03, 1'b1, 1'b1, 1'b1, -1);
      @(negedge clk);
      check("b_perr_level", bus_b.o_fifo_level, 0);
      qp_b.push_back(P_BRK);
      hold(1, 1'b0, 20 * BIT);
      hold(1, 1'b1, 2 * BIT);

      // dut_b: fill 4-deep FIFO, overflow on the fifth, then drain in order.
      @(posedge clk); #1;
      bus_b.i_ready = 1'b0;
      for (int k = 1; k <= 4; k++) qd_b.push_back(8'(k));
      qp_b.push_back(P_OVF);
      send(1, 8'h01, 1'b1, 1'b1, 1'b1, -1);
      send(1, 8'h02, 1'b1, 1'b1, 1'b1, -1);
      send(1, 8'h03, 1'b1, 1'b0, 1'b1, -1);
      send(1, 8'h04, 1'b1, 1'b1, 1'b1, -1);
      send(1, 8'h05, 1'b1, 1'b0, 1'b1, -1);
      @(negedge clk);
      check("b_full_level", bus_b.o_fifo_level, 4);
      check("b_full_valid", bus_b.o_valid, 1);
      check("b_full_head", bus_b.o_data, 8'h01);
      @(posedge clk); #1;
      bus_b.i_ready = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("b_drained_valid", bus_b.o_valid, 0);
      check("b_drained_level", bus_b.o_fifo_level, 0);

      // dut_b: reset during bit 3 with the line low, released still low.
      drain();
      hold(1, 1'b0, 3 * BIT + BIT / 2);
      rst_n = 1'b0;
      hold(1, 1'b0, 10);
      rst_n = 1'b1;
      hold(1, 1'b0, 12 * BIT);
      @(negedge clk);
      check("b_rst_level", bus_b.o_fifo_level, 0);
      hold(1, 1'b1, 2 * BIT);
      bus_b.i_ready = 1'b0;
      qd_b.push_back(8'h3C);
      send(1, 8'h3C, 1'b1, 1'b0, 1'b1, -1);
      @(negedge clk);
      check("b_after_rst_level", bus_b.o_fifo_level, 1);
      @(posedge clk); #1;
      bus_b.i_ready = 1'b1;

      drain();
      repeat (20) @(posedge clk);
      check("a_data_left", qd_a.size(), 0);
      check("a_pulse_left", qp_a.size(), 0);
      check("b_data_left", qd_b.size(), 0);
      check("b_pulse_left", qp_b.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
